// File: rtl/divider_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin divider scheduler.
package divsched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Shift-subtract divider: one edge per quotient bit plus load and settle.
  function automatic int div_lat_default(input int width);
    return 2 * width + 2;
  endfunction

  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/divider_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter
  import divsched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_any
);

  always_comb begin : pick
    int idx;
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    // Walk from farthest to nearest so the closest request to ptr wins last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/divider_rr_scheduler.sv
// Round-robin scheduler sharing one fixed-latency iterative divider among NREQ requesters.
// Define DIVSCHED_ZERO_CHECK_EN to answer divide-by-zero jobs locally without using the divider.
module divider_rr_scheduler
  import divsched_pkg::*;
#(
  parameter  int WIDTH   = 4,
  parameter  int NREQ    = 4,
  parameter  int DIV_LAT = div_lat_default(WIDTH),
  localparam int IDW     = id_width(NREQ),
  localparam int DW      = 2 * WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*DW-1:0]    req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic                  div_valid,
  output logic [DW-1:0]         div_dividend,
  output logic [WIDTH-1:0]      div_divisor,
  input  logic [DW-1:0]         div_quotient,
  input  logic [DW-1:0]         div_remainder,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [DW-1:0]         rsp_quotient,
  output logic [DW-1:0]         rsp_remainder,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int CW = $clog2(DIV_LAT + 1);

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr, gnt_idx;
  logic [NREQ-1:0]  gnt;
  logic             gnt_any, accept, zero_job;
  logic [CW-1:0]    cnt;
  logic [DW-1:0]    sel_dividend;
  logic [WIDTH-1:0] sel_divisor;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

  assign sel_dividend = req_dividend[int'(gnt_idx)*DW +: DW];
  assign sel_divisor  = req_divisor[int'(gnt_idx)*WIDTH +: WIDTH];
  assign accept       = (state == IDLE) && gnt_any;

`ifdef DIVSCHED_ZERO_CHECK_EN
  assign zero_job = (sel_divisor == '0);
`else
  assign zero_job = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = zero_job ? RESP : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == CW'(1)) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) ? gnt : '0;
    div_valid = (state == ISSUE);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr           <= '0;
      cnt           <= '0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      rsp_id        <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
    end else begin
      if (accept) begin
        div_dividend <= sel_dividend;
        div_divisor  <= sel_divisor;
        rsp_id       <= gnt_idx;
`ifdef DIVSCHED_ZERO_CHECK_EN
        if (zero_job) begin
          rsp_quotient  <= '1;
          rsp_remainder <= sel_dividend;
        end
`endif
      end
      if (state == ISSUE)     cnt <= CW'(DIV_LAT);
      else if (state == WAIT) cnt <= cnt - 1'b1;
      // Divider results are stable exactly DIV_LAT edges after the start edge.
      if (state == WAIT && cnt == CW'(1)) begin
        rsp_quotient  <= div_quotient;
        rsp_remainder <= div_remainder;
      end
      if (state == RESP && rsp_ready)
        ptr <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
    end
  end

`ifdef DIVSCHED_ZERO_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rsp_err <= 1'b0;
    else if (accept) rsp_err <= zero_job;
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule
